// File: rtl/adder_tree_pipe_if.sv
// Handshake bundle for adder_tree_pipe: one packed operand beat in, one reduced sum out.
interface adder_tree_pipe_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IN_W   = 8
);
  localparam int unsigned LVLS  = $clog2(NUM_IN);
  localparam int unsigned OUT_W = IN_W + LVLS;

  logic [NUM_IN*IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [OUT_W-1:0]       out_sum;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_valid, busy
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined balanced adder tree: sums NUM_IN operands per beat, one tree level per stage,
// with a global stall so backpressure freezes every stage together.
module adder_tree_pipe #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IN_W   = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  adder_tree_pipe_if.slave bus
);
  localparam int unsigned LVLS = $clog2(NUM_IN);

  logic            w_advance;
  logic [LVLS:1]   w_lvl_valid;

  // The tree moves only when the output slot is empty or being drained this cycle.
  assign w_advance    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_advance && !rst;
  assign bus.busy     = |w_lvl_valid;

  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int unsigned NW = IN_W + k;     // node width at this level
    localparam int unsigned PW = NW - 1;       // node width one level up
    localparam int unsigned NN = NUM_IN >> k;  // node count at this level

    logic [2*NN*PW-1:0] w_prev;
    logic               w_prev_valid;
    logic [NN*NW-1:0]   w_sum;
    logic [NN*NW-1:0]   r_data;
    logic               r_valid;

    if (k == 1) begin : g_src
      assign w_prev       = bus.in_data;
      assign w_prev_valid = bus.in_valid;
    end else begin : g_src
      assign w_prev       = g_lvl[k-1].r_data;
      assign w_prev_valid = g_lvl[k-1].r_valid;
    end

    // Pairwise sums; each child gains one extension bit so no carry is ever dropped.
    for (genvar j = 0; j < NN; j++) begin : g_node
      logic [PW-1:0] w_a;
      logic [PW-1:0] w_b;
      logic          w_a_ext;
      logic          w_b_ext;

      assign w_a     = w_prev[(2*j)*PW +: PW];
      assign w_b     = w_prev[(2*j+1)*PW +: PW];
      assign w_a_ext = SIGNED & w_a[PW-1];
      assign w_b_ext = SIGNED & w_b[PW-1];
      assign w_sum[j*NW +: NW] = {w_a_ext, w_a} + {w_b_ext, w_b};
    end

    // Level register: loads partial sums and valid (bubbles included) whenever the tree advances.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_data  <= w_sum;
        r_valid <= w_prev_valid;
      end
    end

    assign w_lvl_valid[k] = r_valid;
  end

  assign bus.out_sum   = g_lvl[LVLS].r_data;
  assign bus.out_valid = g_lvl[LVLS].r_valid;
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: unsigned 4x8, signed 4x8 and unsigned 8x4 instances.
module tb_adder_tree_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rand_bp = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   q_u[$];
  int   q_s[$];
  int   q_w[$];

  always #5 clk = ~clk;

  adder_tree_pipe_if #(.NUM_IN(4), .IN_W(8)) if_u ();
  adder_tree_pipe_if #(.NUM_IN(4), .IN_W(8)) if_s ();
  adder_tree_pipe_if #(.NUM_IN(8), .IN_W(4)) if_w ();

  adder_tree_pipe #(.NUM_IN(4), .IN_W(8), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .bus(if_u));
  adder_tree_pipe #(.NUM_IN(4), .IN_W(8), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .bus(if_s));
  adder_tree_pipe #(.NUM_IN(8), .IN_W(4), .SIGNED(1'b0)) u_dut_w (.clk(clk), .rst(rst), .bus(if_w));

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Flat reference sum over all lanes of a beat.
  function automatic int model(input int sel, input logic [31:0] d);
    int          n;
    int          w;
    bit          sg;
    int          acc;
    int          v;
    logic [31:0] lane;
    case (sel)
      0:       begin n = 4; w = 8; sg = 1'b0; end
      1:       begin n = 4; w = 8; sg = 1'b1; end
      default: begin n = 8; w = 4; sg = 1'b0; end
    endcase
    acc = 0;
    for (int i = 0; i < n; i++) begin
      lane = (d >> (i * w)) & ((32'd1 << w) - 32'd1);
      v = int'(lane);
      if (sg && v >= (1 << (w - 1))) v = v - (1 << w);
      acc += v;
    end
    return acc;
  endfunction

  task automatic drive(input int sel, input logic [31:0] data, input logic vld);
    case (sel)
      0:       begin if_u.in_data = data; if_u.in_valid = vld; end
      1:       begin if_s.in_data = data; if_s.in_valid = vld; end
      default: begin if_w.in_data = data; if_w.in_valid = vld; end
    endcase
  endtask

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return if_u.in_ready;
      1:       return if_s.in_ready;
      default: return if_w.in_ready;
    endcase
  endfunction

  task automatic push_exp(input int sel, input int exp);
    case (sel)
      0:       q_u.push_back(exp);
      1:       q_s.push_back(exp);
      default: q_w.push_back(exp);
    endcase
  endtask

  // Offer one beat; expected sum is queued in the cycle the beat is accepted.
  task automatic send(input int sel, input logic [31:0] data, input int exp, output int waits);
    waits = 0;
    drive(sel, data, 1'b1);
    forever begin
      @(negedge clk);
      if (get_ready(sel)) begin
        push_exp(sel, exp);
        break;
      end
      waits++;
      if (waits > 200) begin
        check("send_timeout", waits, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    drive(sel, data, 1'b0);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((q_u.size() + q_s.size() + q_w.size()) != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_left", q_u.size() + q_s.size() + q_w.size(), 0);
    @(posedge clk);
    @(negedge clk);
    check("drain_busy", int'(if_u.busy) + int'(if_s.busy) + int'(if_w.busy), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitors: a delivery is out_valid && out_ready outside reset.
  always @(negedge clk) begin
    if (!rst && if_u.out_valid && if_u.out_ready) begin
      if (q_u.size() == 0) check("u_unexpected_out", q_u.size(), 1);
      else                 check("u_sum", int'(if_u.out_sum), q_u.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if_s.out_valid && if_s.out_ready) begin
      if (q_s.size() == 0) check("s_unexpected_out", q_s.size(), 1);
      else                 check("s_sum", int'($signed(if_s.out_sum)), q_s.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if_w.out_valid && if_w.out_ready) begin
      if (q_w.size() == 0) check("w_unexpected_out", q_w.size(), 1);
      else                 check("w_sum", int'(if_w.out_sum), q_w.pop_front());
    end
  end

  // Random downstream backpressure during the mixed-traffic phase.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      if_u.out_ready = 1'($urandom_range(0, 1));
      if_s.out_ready = 1'($urandom_range(0, 1));
      if_w.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          w;
    int          sel;
    logic [31:0] d;

    drive(0, 32'd0, 1'b0);
    drive(1, 32'd0, 1'b0);
    drive(2, 32'd0, 1'b0);
    if_u.out_ready = 1'b1;
    if_s.out_ready = 1'b1;
    if_w.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  int'(if_u.in_ready), 0);
    check("rst_out_valid", int'(if_u.out_valid), 0);
    check("rst_busy",      int'(if_u.busy), 0);
    check("rst_out_sum",   int'(if_u.out_sum), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  int'(if_u.in_ready), 1);
    check("post_rst_out_valid", int'(if_u.out_valid), 0);
    @(posedge clk);
    #1;

    // Basic sum and two-cycle latency
    send(0, 32'h04030201, 10, w);
    check("u_accept_wait", w, 0);
    @(negedge clk);
    check("u_lat_early", int'(if_u.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("u_lat_valid", int'(if_u.out_valid), 1);
    check("u_lat_sum",   int'(if_u.out_sum), 10);
    @(posedge clk);
    #1;

    // Unsigned maximum
    send(0, 32'hFFFFFFFF, 1020, w);
    drain();

    // Back-to-back streaming
    for (int i = 1; i <= 3; i++) begin
      d = {4{8'(i)}};
      send(0, d, 4 * i, w);
      check("stream_rdy", w, 0);
    end
    drain();

    // Backpressure with a full pipeline; in_data wiggles must have no effect
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      send(0, d, model(0, d), w);
    end
    if_u.out_ready = 1'b0;
    repeat (3) begin
      drive(0, $urandom(), 1'b1);
      @(negedge clk);
      check("bp_in_ready",  int'(if_u.in_ready), 0);
      check("bp_out_valid", int'(if_u.out_valid), 1);
      check("bp_hold_sum",  int'(if_u.out_sum), q_u[0]);
      check("bp_busy",      int'(if_u.busy), 1);
      @(posedge clk);
      #1;
    end
    drive(0, 32'd0, 1'b0);
    if_u.out_ready = 1'b1;
    d = 32'h10203040;
    send(0, d, model(0, d), w);
    check("rdy_rise_accept", w, 0);
    drain();

    // Signed boundaries
    send(1, 32'h80808080, -512, w);
    send(1, 32'h0280FF7F, 0, w);
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      send(1, d, model(1, d), w);
    end
    drain();

    // Eight 4-bit lanes: three-cycle latency
    send(2, 32'hFFFFFFFF, 120, w);
    @(negedge clk);
    check("w_lat_e0", int'(if_w.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("w_lat_e1", int'(if_w.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("w_lat_valid", int'(if_w.out_valid), 1);
    check("w_lat_sum",   int'(if_w.out_sum), 120);
    @(posedge clk);
    #1;
    drain();

    // Mixed traffic under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sel = i % 3;
      d = $urandom();
      send(sel, d, model(sel, d), w);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    if_u.out_ready = 1'b1;
    if_s.out_ready = 1'b1;
    if_w.out_ready = 1'b1;
    drain();

    // Reset with two beats in flight: neither may emerge
    send(0, 32'h01020304, 10, w);
    send(0, 32'h05050505, 20, w);
    rst = 1'b1;
    q_u.delete();
    @(negedge clk);
    check("mid_rst_in_ready", int'(if_u.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", int'(if_u.out_valid), 0);
    check("mid_rst_busy",      int'(if_u.busy), 0);
    check("mid_rst_in_ready1", int'(if_u.in_ready), 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    send(0, 32'h07060504, 22, w);
    check("after_rst_wait", w, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
